// File: rtl/dense_seq_pkg.sv
// rtl/dense_seq_pkg.sv - shared types and width helper for the dense-layer sequencer
package dense_seq_pkg;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, WRITE, DONE} state_t;

  typedef struct packed {
    logic bias;
    logic mac;
  } tag_t;

  localparam int CYC_W = 16;

  // A count of 1 still needs a 1-bit address/counter.
  function automatic int clog2_safe(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// rtl/dense_layer_sequencer_if.sv - control/address bundle of the sequencer; cyc_cnt present with DENSE_SEQ_PERF_EN
interface dense_layer_sequencer_if
  import dense_seq_pkg::*;
#(
  parameter int IN_COUNT  = 10,
  parameter int OUT_COUNT = 3
);
  localparam int IW = clog2_safe(IN_COUNT);
  localparam int OW = clog2_safe(OUT_COUNT);
  localparam int WW = clog2_safe(IN_COUNT * OUT_COUNT);

  logic          start;
  logic          busy;
  logic          done;
  logic [IW-1:0] in_adr;
  logic [WW-1:0] w_adr;
  logic [OW-1:0] b_adr;
  logic          acc_ld;
  logic          mac_en;
  logic          out_wr;
  logic [OW-1:0] out_adr;
`ifdef DENSE_SEQ_PERF_EN
  logic [CYC_W-1:0] cyc_cnt;
`endif

  modport master (
    input  start,
`ifdef DENSE_SEQ_PERF_EN
    output cyc_cnt,
`endif
    output busy, done, in_adr, w_adr, b_adr, acc_ld, mac_en, out_wr, out_adr
  );

  modport slave (
    output start,
`ifdef DENSE_SEQ_PERF_EN
    input  cyc_cnt,
`endif
    input  busy, done, in_adr, w_adr, b_adr, acc_ld, mac_en, out_wr, out_adr
  );

endinterface

// File: rtl/dense_seq_delay.sv
// rtl/dense_seq_delay.sv - RD_LAT-deep tag pipeline aligning strobes with RAM read data
module dense_seq_delay
  import dense_seq_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t sr [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RD_LAT; k++) sr[k] <= '0;
    end else begin
      sr[0] <= tag_in;
      for (int k = 1; k < RD_LAT; k++) sr[k] <= sr[k-1];
    end
  end

  assign tag_out = sr[RD_LAT-1];

endmodule

// File: rtl/dense_layer_sequencer.sv
// rtl/dense_layer_sequencer.sv - dense-layer control FSM and address counters; DENSE_SEQ_PERF_EN adds cyc_cnt
module dense_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter int IN_COUNT  = 10,
  parameter int OUT_COUNT = 3,
  parameter int RD_LAT    = 1
) (
  input logic                     clk,
  input logic                     rst,
  dense_layer_sequencer_if.master bus
);

  localparam int IW = clog2_safe(IN_COUNT);
  localparam int OW = clog2_safe(OUT_COUNT);
  localparam int WW = clog2_safe(IN_COUNT * OUT_COUNT);
  localparam int DW = clog2_safe(RD_LAT);
  localparam logic [IW-1:0] I_LAST = IW'(IN_COUNT - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUT_COUNT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] i_q;
  logic [OW-1:0] o_q;
  logic [WW-1:0] w_q;
  logic [DW-1:0] d_q;
  tag_t          tag_in, tag_out;
  logic          busy, done, out_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = BIAS;
      BIAS:    state_d = MAC;
      MAC:     if (i_q == I_LAST) state_d = DRAIN;
      DRAIN:   if (d_q == D_LAST) state_d = WRITE;
      WRITE:   state_d = (o_q == O_LAST) ? DONE : BIAS;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    out_wr = (state_q == WRITE);
    tag_in = '{bias: (state_q == BIAS), mac: (state_q == MAC)};
  end

  // w_q stops on the final MAC so it never wraps past the last weight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
      o_q <= '0;
      w_q <= '0;
      d_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          o_q <= '0;
          w_q <= '0;
        end
        BIAS: i_q <= '0;
        MAC: begin
          d_q <= '0;
          if (i_q != I_LAST) i_q <= i_q + 1'b1;
          if (!(i_q == I_LAST && o_q == O_LAST)) w_q <= w_q + 1'b1;
        end
        DRAIN: if (d_q != D_LAST) d_q <= d_q + 1'b1;
        WRITE: if (o_q != O_LAST) o_q <= o_q + 1'b1;
        default: ;
      endcase
    end
  end

  dense_seq_delay #(.RD_LAT(RD_LAT)) u_delay (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.out_wr  = out_wr;
  assign bus.acc_ld  = tag_out.bias;
  assign bus.mac_en  = tag_out.mac;
  assign bus.in_adr  = i_q;
  assign bus.w_adr   = w_q;
  assign bus.b_adr   = o_q;
  assign bus.out_adr = o_q;

`ifdef DENSE_SEQ_PERF_EN
  logic [CYC_W-1:0] cnt_q, cyc_q;

  // Value latched on done counts busy cycles before the done cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      if (state_q == IDLE && bus.start) cnt_q <= '0;
      else if (busy && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
      if (done) cyc_q <= cnt_q;
    end
  end

  assign bus.cyc_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb/tb_dense_layer_sequencer.sv - directed bench for dense_layer_sequencer (cyc_cnt checked with DENSE_SEQ_PERF_EN)
module tb_dense_layer_sequencer;

  localparam int IN_A = 10, OUT_A = 3, RL_A = 1;
  localparam int P_A  = IN_A + RL_A + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dense_layer_sequencer_if #(.IN_COUNT(IN_A), .OUT_COUNT(OUT_A)) a_if ();
  dense_layer_sequencer_if #(.IN_COUNT(4),    .OUT_COUNT(2))     b_if ();
  dense_layer_sequencer_if #(.IN_COUNT(1),    .OUT_COUNT(1))     c_if ();

  dense_layer_sequencer #(.IN_COUNT(IN_A), .OUT_COUNT(OUT_A), .RD_LAT(RL_A)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if));
  dense_layer_sequencer #(.IN_COUNT(4), .OUT_COUNT(2), .RD_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if));
  dense_layer_sequencer #(.IN_COUNT(1), .OUT_COUNT(1), .RD_LAT(1)) dut_c (
    .clk(clk), .rst(rst), .bus(c_if));

  // Model RAMs and accumulator of the dense unit behind instance B.
  int xb [4] = '{1, 2, 3, 4};
  int wb [8] = '{1, 1, 1, 1, 2, 0, 1, 3};
  int bb [2] = '{5, 7};
  int xp [2], wp [2], bp [2];
  int acc_b;
  int ob [2] = '{-1, -1};
  int overlap_b = 0;

  always @(posedge clk) begin
    xp[0] <= xb[b_if.in_adr];
    xp[1] <= xp[0];
    wp[0] <= wb[b_if.w_adr];
    wp[1] <= wp[0];
    bp[0] <= bb[b_if.b_adr];
    bp[1] <= bp[0];
    if (b_if.acc_ld && b_if.mac_en) overlap_b <= overlap_b + 1;
    if (b_if.acc_ld)      acc_b <= bp[1];
    else if (b_if.mac_en) acc_b <= acc_b + xp[1] * wp[1];
    if (b_if.out_wr)      ob[b_if.out_adr] <= acc_b;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] a_vec();
    return {27'd0, a_if.busy, a_if.done, a_if.acc_ld, a_if.mac_en, a_if.out_wr};
  endfunction

  // Start pulse in cycle 0; start also high in cycles 1..hold_to and in cycle pulse_at.
  task automatic run_pass_a(input int hold_to, input int pulse_at);
    int busy_n = 0, wr_n = 0, done_at = -1, p, o;
    logic [31:0] exp;
    @(negedge clk);
    a_if.start = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      @(negedge clk);
      a_if.start = (n <= hold_to) || (n == pulse_at);
      p = (n - 1) % P_A;
      o = (n - 1) / P_A;
      if (n < P_A * OUT_A + 1)
        exp = {27'd0, 1'b1, 1'b0, p == RL_A, (p >= 1 + RL_A) && (p <= IN_A + RL_A), p == P_A - 1};
      else if (n == P_A * OUT_A + 1)
        exp = 32'b11000;
      else
        exp = 32'd0;
      check("strobes", a_vec(), exp);
      if (n < P_A * OUT_A + 1) begin
        if (p == 0) check("b_adr", a_if.b_adr, o);
        if (p >= 1 && p <= IN_A) begin
          check("w_adr", a_if.w_adr, o * IN_A + p - 1);
          check("in_adr", a_if.in_adr, p - 1);
        end
        if (p == P_A - 1) check("out_adr", a_if.out_adr, o);
      end
      if (a_if.busy && !a_if.done) busy_n++;
      if (a_if.out_wr) wr_n++;
      if (a_if.done && done_at < 0) done_at = n;
    end
    check("done_cycle", done_at, 40);
    check("busy_cycles", busy_n, 39);
    check("out_wr_count", wr_n, 3);
    check("w_adr_hold", a_if.w_adr, 29);
    check("in_adr_hold", a_if.in_adr, 9);
    check("b_adr_hold", a_if.b_adr, 2);
`ifdef DENSE_SEQ_PERF_EN
    check("cyc_cnt", a_if.cyc_cnt, 39);
`endif
  endtask

  initial begin
    int any_n, done_b, done_c, mac_c, wr_c;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    c_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", a_vec(), 0);
    check("reset_adr", {a_if.in_adr, a_if.w_adr, a_if.b_adr, a_if.out_adr}, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_outputs", a_vec(), 0);

    run_pass_a(0, -1);
    run_pass_a(38, 40);

    // Abort in cycle 17 of a pass.
    @(negedge clk);
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    repeat (16) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", a_vec(), 0);
    check("abort_adr", {a_if.in_adr, a_if.w_adr, a_if.b_adr, a_if.out_adr}, 0);
    rst = 1'b1;
    any_n = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_vec() != 0) any_n++;
    end
    check("abort_quiet", any_n, 0);
    run_pass_a(0, -1);

    // Instances B (scoreboard) and C (single neuron, single input).
    done_b = -1; done_c = -1; mac_c = 0; wr_c = 0;
    @(negedge clk);
    b_if.start = 1'b1;
    c_if.start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      b_if.start = 1'b0;
      c_if.start = 1'b0;
      if (b_if.done && done_b < 0) done_b = n;
      if (c_if.done && done_c < 0) done_c = n;
      if (c_if.mac_en) mac_c++;
      if (c_if.out_wr) wr_c++;
    end
    check("b_done_cycle", done_b, 17);
    check("b_out0", ob[0], 15);
    check("b_out1", ob[1], 24);
    check("b_overlap", overlap_b, 0);
    check("b_w_adr_hold", b_if.w_adr, 7);
    check("c_done_cycle", done_c, 5);
    check("c_mac_count", mac_c, 1);
    check("c_wr_count", wr_c, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
